// File: rtl/alu_mc.sv
// Multi-cycle registered ALU: single-cycle ops complete one edge after accept,
// MUL (shift-add) and SHN (one bit per cycle) iterate before completing.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] INPUTA,
  input  logic [WIDTH-1:0] INPUTB,
  input  logic             SC_IN,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             SC_OUT,
  output logic             ZERO,
  output logic             OUT_VALID
);

  localparam int SAW = $clog2(WIDTH);
  localparam int CW  = SAW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHN} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_LSH = 3'b001, OP_RSH = 3'b010, OP_XOR = 3'b011,
    OP_AND = 3'b100, OP_CMP = 3'b101, OP_MUL = 3'b110, OP_SHN = 3'b111
  } op_e;

  state_e             r_state, w_state_nxt;
  op_e                r_op, w_op_in;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_ci, r_pend;
  logic [2*WIDTH-1:0] r_mc, r_acc, w_acc_nxt;
  logic [CW-1:0]      r_cnt, r_n, w_cnt_nxt, w_target;
  logic [SAW-1:0]     w_amt;
  logic               w_accept, w_start_mul, w_start_shn, w_done;
  logic [WIDTH-1:0]   w_res, w_sh_nxt;
  logic               w_res_sc;
  logic [WIDTH:0]     w_sum, w_diff;

  logic [WIDTH-1:0]   r_out, r_out_hi;
  logic               r_sc, r_zero, r_valid;

  assign w_op_in     = op_e'(OP);
  assign w_amt       = INPUTB[SAW-1:0];
  assign w_accept    = IN_VALID && IN_READY;
  assign w_start_mul = w_accept && (w_op_in == OP_MUL);
  assign w_start_shn = w_accept && (w_op_in == OP_SHN) && (w_amt != '0);

  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_target  = (r_state == S_MUL) ? CW'(WIDTH) : r_n;
  assign w_done    = (r_state != S_IDLE) && (w_cnt_nxt == w_target);
  assign w_acc_nxt = r_acc + (r_b[0] ? r_mc : '0);
  assign w_sh_nxt  = {r_a[WIDTH-2:0], 1'b0};

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_ci};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_mul)      w_state_nxt = S_MUL;
        else if (w_start_shn) w_state_nxt = S_SHN;
      end
      S_MUL, S_SHN: if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (r_state == S_IDLE);
    OUT       = r_out;
    OUT_HI    = r_out_hi;
    SC_OUT    = r_sc;
    ZERO      = r_zero;
    OUT_VALID = r_valid;
  end

  // Single-cycle result, evaluated from operands latched at the accept edge.
  always_comb begin
    w_res    = '0;
    w_res_sc = 1'b0;
    case (r_op)
      OP_ADD:  {w_res_sc, w_res} = w_sum;
      OP_LSH:  {w_res_sc, w_res} = {r_a, r_ci};
      OP_RSH:  {w_res, w_res_sc} = {r_ci, r_a};
      OP_XOR:  w_res = r_a ^ r_b;
      OP_AND:  w_res = r_a & r_b;
      OP_CMP:  {w_res_sc, w_res} = w_diff;
      OP_SHN:  w_res = r_a;
      default: w_res = '0;
    endcase
  end

  // r_a doubles as the SHN shift register and r_b as the MUL multiplier.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_ci     <= 1'b0;
      r_pend   <= 1'b0;
      r_mc     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_n      <= '0;
      r_out    <= '0;
      r_out_hi <= '0;
      r_sc     <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_pend  <= w_accept && !w_start_mul && !w_start_shn;

      if (w_accept) begin
        r_op  <= w_op_in;
        r_a   <= INPUTA;
        r_b   <= INPUTB;
        r_ci  <= SC_IN;
        r_mc  <= {{WIDTH{1'b0}}, INPUTA};
        r_acc <= '0;
        r_cnt <= '0;
        r_n   <= {1'b0, w_amt};
      end else if (r_state == S_MUL) begin
        r_acc <= w_acc_nxt;
        r_mc  <= r_mc << 1;
        r_b   <= r_b >> 1;
        r_cnt <= w_cnt_nxt;
      end else if (r_state == S_SHN) begin
        r_a   <= w_sh_nxt;
        r_cnt <= w_cnt_nxt;
      end

      if (r_pend) begin
        r_out    <= w_res;
        r_out_hi <= '0;
        r_sc     <= w_res_sc;
        r_zero   <= (w_res == '0);
        r_valid  <= 1'b1;
      end else if (r_state == S_MUL && w_done) begin
        {r_out_hi, r_out} <= w_acc_nxt;
        r_sc     <= |w_acc_nxt[2*WIDTH-1:WIDTH];
        r_zero   <= (w_acc_nxt == '0);
        r_valid  <= 1'b1;
      end else if (r_state == S_SHN && w_done) begin
        r_out    <= w_sh_nxt;
        r_out_hi <= '0;
        r_sc     <= r_a[WIDTH-1];
        r_zero   <= (w_sh_nxt == '0);
        r_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=8.
module tb_alu_mc;
  localparam int W = 8;
  localparam logic [2:0] ADD = 3'd0, LSH = 3'd1, RSH = 3'd2, XOR_ = 3'd3,
                         AND_ = 3'd4, CMP = 3'd5, MUL = 3'd6, SHN = 3'd7;

  logic         CLK = 1'b0, RST_N = 1'b1, IN_VALID = 1'b0, SC_IN = 1'b0;
  logic [2:0]   OP = 3'd0;
  logic [W-1:0] INPUTA = '0, INPUTB = '0;
  logic         IN_READY, SC_OUT, ZERO, OUT_VALID;
  logic [W-1:0] OUT, OUT_HI;

  int n_vec = 0;
  int n_miss = 0;

  alu_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP(OP), .INPUTA(INPUTA), .INPUTB(INPUTB), .SC_IN(SC_IN),
    .OUT(OUT), .OUT_HI(OUT_HI), .SC_OUT(SC_OUT), .ZERO(ZERO),
    .OUT_VALID(OUT_VALID)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one request and returns #1 after the edge on which it was accepted.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci);
    int t;
    t = 0;
    while (!IN_READY && t < 20) begin
      tick();
      t++;
    end
    if (!IN_READY) begin
      n_vec++; n_miss++;
      $display("FAIL issue_ready: IN_READY=%b required 1", IN_READY);
    end
    OP = op; INPUTA = a; INPUTB = b; SC_IN = ci; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    #2;
    n_vec++;
    if ({OUT, OUT_HI, SC_OUT, ZERO, OUT_VALID} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: got OUT=%h HI=%h SC=%b Z=%b V=%b required all 0",
               OUT, OUT_HI, SC_OUT, ZERO, OUT_VALID);
    end
    n_vec++;
    if (IN_READY !== 1'b1) begin
      n_miss++; $display("FAIL reset_ready: got %b required 1", IN_READY);
    end
    tick(); tick();
    RST_N = 1'b1;
    tick();
    n_vec++;
    if ({OUT_VALID, IN_READY} !== 2'b01) begin
      n_miss++; $display("FAIL post_reset_idle: V/RDY got %b required 01", {OUT_VALID, IN_READY});
    end
  endtask

  task automatic test_add();
    OP = ADD; INPUTA = 8'hFF; INPUTB = 8'h01; SC_IN = 1'b0; IN_VALID = 1'b1;
    tick();
    OP = ADD; INPUTA = 8'h10; INPUTB = 8'h20; SC_IN = 1'b1;
    tick();
    IN_VALID = 1'b0;
    n_vec++;
    if ({OUT, SC_OUT, ZERO, OUT_VALID} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
      n_miss++;
      $display("FAIL add_ff_01: got OUT=%h SC=%b Z=%b V=%b required 00 1 1 1",
               OUT, SC_OUT, ZERO, OUT_VALID);
    end
    n_vec++;
    if (OUT_HI !== 8'h00) begin
      n_miss++; $display("FAIL add_hi: got %h required 00", OUT_HI);
    end
    tick();
    n_vec++;
    if ({OUT, SC_OUT, ZERO, OUT_VALID} !== {8'h31, 1'b0, 1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL add_b2b: got OUT=%h SC=%b Z=%b V=%b required 31 0 0 1",
               OUT, SC_OUT, ZERO, OUT_VALID);
    end
    tick();
    n_vec++;
    if ({OUT, OUT_VALID} !== {8'h31, 1'b0}) begin
      n_miss++; $display("FAIL add_hold: got OUT=%h V=%b required 31 0", OUT, OUT_VALID);
    end
  endtask

  task automatic test_single();
    logic [2:0]   ops[6] = '{LSH, RSH, CMP, CMP, XOR_, AND_};
    logic [W-1:0] as[6]  = '{8'hB3, 8'hB3, 8'h05, 8'h07, 8'hA5, 8'hF0};
    logic [W-1:0] bs[6]  = '{8'h00, 8'h00, 8'h07, 8'h07, 8'h0F, 8'h0F};
    logic         cis[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] eo[6]  = '{8'h67, 8'hD9, 8'hFE, 8'h00, 8'hAA, 8'h00};
    logic         esc[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         ez[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], cis[i]);
      INPUTA = ~as[i]; INPUTB = ~bs[i]; SC_IN = ~cis[i]; OP = ~ops[i];
      tick();
      n_vec++;
      if ({OUT, SC_OUT, ZERO, OUT_VALID, OUT_HI} !== {eo[i], esc[i], ez[i], 1'b1, 8'h00}) begin
        n_miss++;
        $display("FAIL single_%0d op=%0d: got OUT=%h SC=%b Z=%b V=%b HI=%h required %h %b %b 1 00",
                 i, ops[i], OUT, SC_OUT, ZERO, OUT_VALID, OUT_HI, eo[i], esc[i], ez[i]);
      end
    end
  endtask

  task automatic test_mul();
    issue(MUL, 8'hFF, 8'hFF, 1'b0);
    n_vec++;
    if (IN_READY !== 1'b0) begin
      n_miss++; $display("FAIL mul_busy: IN_READY got %b required 0", IN_READY);
    end
    OP = ADD; INPUTA = 8'h01; INPUTB = 8'h01; IN_VALID = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) begin
        n_vec++;
        if ({OUT_VALID, IN_READY} !== 2'b00) begin
          n_miss++;
          $display("FAIL mul_wait_%0d: V/RDY got %b required 00", i, {OUT_VALID, IN_READY});
        end
      end
    end
    IN_VALID = 1'b0;
    n_vec++;
    if ({OUT_HI, OUT, SC_OUT, ZERO, OUT_VALID, IN_READY} !==
        {8'hFE, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      n_miss++;
      $display("FAIL mul_ff_ff: got HI=%h OUT=%h SC=%b Z=%b V=%b RDY=%b required FE 01 1 0 1 1",
               OUT_HI, OUT, SC_OUT, ZERO, OUT_VALID, IN_READY);
    end
    tick();
    n_vec++;
    if ({OUT, OUT_VALID} !== {8'h01, 1'b0}) begin
      n_miss++; $display("FAIL mul_no_queue: got OUT=%h V=%b required 01 0", OUT, OUT_VALID);
    end
    issue(MUL, 8'h00, 8'h5A, 1'b0);
    repeat (8) tick();
    n_vec++;
    if ({OUT_HI, OUT, SC_OUT, ZERO, OUT_VALID} !== {8'h00, 8'h00, 1'b0, 1'b1, 1'b1}) begin
      n_miss++;
      $display("FAIL mul_zero: got HI=%h OUT=%h SC=%b Z=%b V=%b required 00 00 0 1 1",
               OUT_HI, OUT, SC_OUT, ZERO, OUT_VALID);
    end
  endtask

  task automatic test_shn();
    logic [W-1:0] bs[4]  = '{8'h03, 8'h01, 8'h00, 8'h0B};
    int           lat[4] = '{3, 1, 1, 3};
    logic [W-1:0] eo[4]  = '{8'h08, 8'h02, 8'h81, 8'h08};
    logic         esc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(SHN, 8'h81, bs[i], 1'b1);
      INPUTA = 8'hFF; INPUTB = 8'h07;
      for (int j = 1; j <= lat[i]; j++) begin
        tick();
        if (j < lat[i]) begin
          n_vec++;
          if (OUT_VALID !== 1'b0) begin
            n_miss++; $display("FAIL shn_%0d_early_%0d: V got %b required 0", i, j, OUT_VALID);
          end
        end
      end
      n_vec++;
      if ({OUT, SC_OUT, ZERO, OUT_VALID, OUT_HI} !== {eo[i], esc[i], 1'b0, 1'b1, 8'h00}) begin
        n_miss++;
        $display("FAIL shn_%0d b=%h: got OUT=%h SC=%b Z=%b V=%b HI=%h required %h %b 0 1 00",
                 i, bs[i], OUT, SC_OUT, ZERO, OUT_VALID, OUT_HI, eo[i], esc[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    issue(MUL, 8'hFF, 8'hFF, 1'b0);
    tick(); tick(); tick();
    RST_N = 1'b0;
    #1;
    n_vec++;
    if ({OUT, OUT_HI, SC_OUT, ZERO, OUT_VALID, IN_READY} !== {8'h00, 8'h00, 4'b0001}) begin
      n_miss++;
      $display("FAIL rst_mid_mul: got OUT=%h HI=%h SC=%b Z=%b V=%b RDY=%b required 00 00 0 0 0 1",
               OUT, OUT_HI, SC_OUT, ZERO, OUT_VALID, IN_READY);
    end
    seen = 1'b0;
    tick();
    RST_N = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      seen |= OUT_VALID;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_miss++; $display("FAIL rst_discard: OUT_VALID seen=%b required 0", seen);
    end
    issue(ADD, 8'h02, 8'h03, 1'b0);
    tick();
    n_vec++;
    if ({OUT, SC_OUT, ZERO, OUT_VALID} !== {8'h05, 1'b0, 1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL rst_then_add: got OUT=%h SC=%b Z=%b V=%b required 05 0 0 1",
               OUT, SC_OUT, ZERO, OUT_VALID);
    end
  endtask

  task automatic test_stability();
    int cyc;
    issue(MUL, 8'h0F, 8'h11, 1'b0);
    cyc = 0;
    for (int j = 1; j <= 20; j++) begin
      OP = 3'($urandom); INPUTA = 8'($urandom); INPUTB = 8'($urandom); SC_IN = 1'($urandom);
      tick();
      if (OUT_VALID === 1'b1) begin
        cyc = j;
        break;
      end
    end
    n_vec++;
    if (cyc != 8) begin
      n_miss++; $display("FAIL stab_latency: got %0d cycles required 8", cyc);
    end
    n_vec++;
    if ({OUT_HI, OUT, SC_OUT, ZERO} !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL stab_result: got HI=%h OUT=%h SC=%b Z=%b required 00 FF 0 0",
               OUT_HI, OUT, SC_OUT, ZERO);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single();
    test_mul();
    test_shn();
    test_reset_mid_mul();
    test_stability();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised ALU for the basic processor datapath. It is the registered successor of the single-cycle 8-bit ALU, and keeps the same opcode set semantics for ADD/LSH/RSH/XOR/AND. It adds a borrow-reporting compare, an iterative shift-add multiply with a double-width result, and an iterative shift-left-by-N. Operations are issued through a valid/ready handshake; results and flags are registered and held until the next completion.

## Interface
- WIDTH, 8, operand/result width; power of two, ≥4.
- SAW, $clog2(WIDTH), shift-amount field width (derived; not overridden).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  block can accept; high only in IDLE.
- OP  in  3  opcode: 000 ADD, 001 LSH, 010 RSH, 011 XOR, 100 AND, 101 CMP, 110 MUL, 111 SHN.
- INPUTA  in  WIDTH  operand A.
- INPUTB  in  WIDTH  operand B; for SHN only B[SAW-1:0] is used.
- SC_IN  in  1  shift-in/carry-in.
- OUT  out  WIDTH  result (low word).
- OUT_HI  out  WIDTH  high word of the MUL product; 0 for all other ops.
- SC_OUT  out  1  carry/shift-out/borrow flag.
- ZERO  out  1  zero flag.
- OUT_VALID  out  1  one-cycle pulse when OUT/OUT_HI/SC_OUT/ZERO update.

## Operation
- Accept: IN_VALID && IN_READY at a rising edge. OP, INPUTA, INPUTB and SC_IN are latched at that edge. Later changes to the inputs have no effect on the operation in flight.
- States:
  - IDLE: IN_READY=1.
  - MUL: iterate shift-add.
  - SHN: iterate one-bit left shifts.
- IDLE → MUL on accepting op 110.
- IDLE → SHN on accepting op 111 with amount ≠0.
- All other accepts complete directly from IDLE.
- ADD: {SC_OUT,OUT} = A + B + SC_IN, computed at WIDTH+1 bits.
- LSH: {SC_OUT,OUT} = {A,SC_IN}.
- RSH: {OUT,SC_OUT} = {SC_IN,A}.
- XOR, AND: bitwise on A and B; SC_OUT=0.
- CMP: OUT = (A − B) mod 2^WIDTH; SC_OUT = 1 iff A < B (unsigned borrow).
- MUL: unsigned {OUT_HI,OUT} = A × B. Implemented as exactly WIDTH shift-add iterations, one per cycle, on a 2·WIDTH accumulator. SC_OUT = (OUT_HI ≠ 0).
- SHN: logical left shift of A by n = B[SAW-1:0], one bit per cycle, zero fill.
  - n=0: OUT=A, SC_OUT=0, completes like a single-cycle op.
  - n>0: SC_OUT = A[WIDTH−n], the last bit shifted out.
- ZERO: 1 iff the full result is zero. For MUL that is {OUT_HI,OUT}; for all other ops it is OUT. It is computed from the final value, never from intermediate iterations.
- Outputs, flags and OUT_HI are registered. They update only at a completion edge and hold their value otherwise.
- Requests while IN_READY=0 are ignored and not queued. The requester must hold IN_VALID until accepted.

## Timing
- Reset (RST_N low, asynchronous):
  - state=IDLE.
  - IN_READY=1.
  - OUT=0, OUT_HI=0, SC_OUT=0, ZERO=0, OUT_VALID=0.
  - Iteration counter and accumulator cleared.
  - An in-flight operation is discarded with no OUT_VALID.
- Latency, for an op accepted at edge k:
  - Single-cycle ops (and SHN n=0): results update at edge k+1; OUT_VALID=1 for the cycle after edge k+1.
  - MUL: results update at edge k+WIDTH.
  - SHN n>0: results update at edge k+n.
- IN_READY is 0 from edge k to the completion edge of multi-cycle ops. It returns to 1 in the same cycle OUT_VALID is high.
- Throughput:
  - Single-cycle ops: one per clock, back-to-back.
  - A new op may be accepted in the cycle OUT_VALID is high.
- Iteration counter is SAW+1 bits wide; wrap-around is not permitted. Completion is detected when the count reaches the target (WIDTH or n).
- OUT_VALID never stays high for two consecutive cycles for multi-cycle ops. Back-to-back single-cycle ops give consecutive pulses.

## Test plan
(All scenarios use WIDTH=8.)
- ADD A=0xFF, B=0x01, SC_IN=0 → one cycle later: OUT=0x00, SC_OUT=1, ZERO=1, OUT_VALID one-cycle pulse. Then ADD 0x10+0x20 with SC_IN=1 issued back-to-back → OUT=0x31, ZERO=0.
- LSH A=0xB3, SC_IN=1 → OUT=0x67, SC_OUT=1. RSH A=0xB3, SC_IN=1 → OUT=0xD9, SC_OUT=1. CMP 0x05 vs 0x07 → OUT=0xFE, SC_OUT=1, ZERO=0. CMP 0x07 vs 0x07 → OUT=0x00, SC_OUT=0, ZERO=1.
- MUL 0xFF×0xFF → exactly 8 cycles after accept: OUT=0x01, OUT_HI=0xFE, SC_OUT=1, ZERO=0. IN_READY low for 8 cycles; an IN_VALID asserted during that window is not accepted. MUL 0x00×0x5A → OUT=OUT_HI=0, ZERO=1.
- SHN A=0x81, B=3 → after 3 cycles: OUT=0x08, SC_OUT=0. SHN A=0x81, B=1 → after 1 cycle: OUT=0x02, SC_OUT=1. SHN B=0 → 1 cycle: OUT=0x81, SC_OUT=0. SHN B=0x0B uses amount 3.
- Reset mid-MUL: drop RST_N 3 cycles after accept → outputs immediately 0, IN_READY=1, no OUT_VALID. After release, ADD 0x02+0x03 → OUT=0x05.
- Operand stability: change INPUTA/INPUTB/OP every cycle during MUL 0x0F×0x11 → result still 0x00FF, i.e. OUT=0xFF, OUT_HI=0x00.
